// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory read responder: line geometry, FSM states and
// helpers that size a request in SRAM lines and response beats.
package mem_rd_pkg;

   localparam int unsigned LINE_BYTES = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain
   } state_e;

   // Number of 16-byte lines touched by nbytes starting at byte offset within a line.
   function automatic int unsigned calc_lines(input int unsigned offset,
                                              input int unsigned nbytes);
      return (offset + nbytes + LINE_BYTES - 1) / LINE_BYTES;
   endfunction

   // Number of response beats needed to carry nbytes.
   function automatic int unsigned calc_beats(input int unsigned nbytes);
      return (nbytes + LINE_BYTES - 1) / LINE_BYTES;
   endfunction

endpackage

// File: rtl/mem_rd_byte_align.sv
// Byte aligner: picks 16 consecutive bytes out of two adjacent SRAM lines, starting at
// byte offset_i of the older line.
module mem_rd_byte_align #(
   parameter int unsigned MEM_DATA_BUS = 128
) (
   input  logic [MEM_DATA_BUS-1:0] prev_line_i,
   input  logic [MEM_DATA_BUS-1:0] cur_line_i,
   input  logic [3:0]              offset_i,
   output logic [MEM_DATA_BUS-1:0] beat_o
);

   logic [2*MEM_DATA_BUS-1:0] joined;

   // Shift the line pair down by offset_i bytes and keep the low beat.
   always_comb begin
      joined = {cur_line_i, prev_line_i} >> {offset_i, 3'b000};
      beat_o = joined[MEM_DATA_BUS-1:0];
   end

endmodule

// File: rtl/mem_rd_responder.sv
// Memory read responder: accepts a byte-addressed read, fetches the covering SRAM lines
// back to back and returns the bytes as zero-padded 16-byte beats.
// Define MEM_RD_RESP_ERR_EN to reject zero-length and oversize requests with a
// mem_rd_err pulse; otherwise zero-length requests are dropped and oversize ones clamped.
module mem_rd_responder
   import mem_rd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH           = 12,
   parameter int unsigned MAX_BYTES_TO_RD      = 20,
   parameter int unsigned LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD),
   parameter int unsigned MEM_DATA_BUS         = 128
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [ADDR_WIDTH-1:0]           mem_start_addr,
   input  logic [LOG2_MAX_BYTES_TO_RD-1:0] mem_bytes,
   input  logic                            mem_rd_req,
   output logic [MEM_DATA_BUS-1:0]         mem_data,
   output logic                            mem_data_vld,
   output logic                            mem_busy,
   output logic                            sram_rd_en,
   output logic [ADDR_WIDTH-5:0]           sram_addr,
   input  logic [MEM_DATA_BUS-1:0]         sram_rdata
`ifdef MEM_RD_RESP_ERR_EN
   ,
   output logic                            mem_rd_err
`endif
);

   localparam int unsigned NW   = LOG2_MAX_BYTES_TO_RD;
   localparam int unsigned CntW = LOG2_MAX_BYTES_TO_RD + 1;
   localparam int unsigned LW   = ADDR_WIDTH - 4;

   typedef logic [CntW-1:0] cnt_t;

   state_e                  state_q, state_d;
   logic [3:0]              off_q, off_d;
   logic [NW-1:0]           nbytes_q, nbytes_d;
   cnt_t                    lines_q, lines_d;    // lines to read
   cnt_t                    beats_q, beats_d;    // beats to return
   cnt_t                    iss_q, iss_d;        // lines issued
   cnt_t                    rcv_q, rcv_d;        // lines captured into line_q history
   cnt_t                    bj_q, bj_d;          // beats emitted
   logic                    rd_pend_q, rd_pend_d; // sram_rdata valid this cycle
   logic [MEM_DATA_BUS-1:0] line_q, line_d;      // most recently returned line
   logic                    rd_en_q, rd_en_d;
   logic [LW-1:0]           addr_q, addr_d;
   logic [MEM_DATA_BUS-1:0] data_q, data_d;
   logic                    vld_q, vld_d;
`ifdef MEM_RD_RESP_ERR_EN
   logic                    err_q, err_d;
`endif

   logic [NW-1:0]           req_n;
   logic                    req_bad;
   cnt_t                    avail;
   int unsigned             beat_start, last_byte, end_line, byte_cnt, n_int;
   logic                    two_line, beat_rdy;
   logic [MEM_DATA_BUS-1:0] align_prev, aligned, beat_masked;

   // Request qualification: reject, drop or clamp the byte count.
   always_comb begin
      req_n = mem_bytes;
`ifdef MEM_RD_RESP_ERR_EN
      req_bad = (mem_bytes == '0) || (32'(mem_bytes) > MAX_BYTES_TO_RD);
`else
      req_bad = (mem_bytes == '0);
      if (32'(mem_bytes) > MAX_BYTES_TO_RD) req_n = NW'(MAX_BYTES_TO_RD);
`endif
   end

   // Beat j starts in line j; it spans into line j+1 only when its last byte lands there.
   always_comb begin
      n_int      = 32'(nbytes_q);
      beat_start = LINE_BYTES * 32'(bj_q);
      last_byte  = (beat_start + LINE_BYTES - 1 < n_int) ? beat_start + LINE_BYTES - 1
                                                          : n_int - 1;
      end_line   = (32'(off_q) + last_byte) / LINE_BYTES;
      byte_cnt   = (n_int - beat_start >= LINE_BYTES) ? LINE_BYTES : n_int - beat_start;
      avail      = rcv_q + cnt_t'(rd_pend_q);
      two_line   = end_line > 32'(bj_q);
      beat_rdy   = (state_q != StIdle) && (bj_q < beats_q) && (end_line < 32'(avail));
      // A single-line beat uses the fresh line unless it is stalled behind its neighbour.
      align_prev = (two_line || !rd_pend_q) ? line_q : sram_rdata;
   end

   mem_rd_byte_align #(
      .MEM_DATA_BUS (MEM_DATA_BUS)
   ) u_align (
      .prev_line_i (align_prev),
      .cur_line_i  (sram_rdata),
      .offset_i    (off_q),
      .beat_o      (aligned)
   );

   // Zero the bytes beyond the end of the request.
   always_comb begin
      beat_masked = aligned;
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
         if (k >= byte_cnt) beat_masked[8*k +: 8] = 8'h00;
      end
   end

   // Next-state logic for the FSM, counters and output registers.
   always_comb begin
      state_d   = state_q;
      off_d     = off_q;
      nbytes_d  = nbytes_q;
      lines_d   = lines_q;
      beats_d   = beats_q;
      iss_d     = iss_q;
      rcv_d     = rcv_q + cnt_t'(rd_pend_q);
      bj_d      = bj_q;
      rd_pend_d = rd_en_q;
      line_d    = rd_pend_q ? sram_rdata : line_q;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      data_d    = '0;
      vld_d     = 1'b0;
`ifdef MEM_RD_RESP_ERR_EN
      err_d     = 1'b0;
`endif

      if (beat_rdy) begin
         vld_d  = 1'b1;
         data_d = beat_masked;
         bj_d   = bj_q + cnt_t'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (mem_rd_req && !req_bad) begin
               state_d  = StRead;
               off_d    = mem_start_addr[3:0];
               nbytes_d = req_n;
               lines_d  = cnt_t'(calc_lines(32'(mem_start_addr[3:0]), 32'(req_n)));
               beats_d  = cnt_t'(calc_beats(32'(req_n)));
               rd_en_d  = 1'b1;
               addr_d   = mem_start_addr[ADDR_WIDTH-1:4];
               iss_d    = cnt_t'(1);
               rcv_d    = '0;
               bj_d     = '0;
            end
`ifdef MEM_RD_RESP_ERR_EN
            else if (mem_rd_req) begin
               err_d = 1'b1;
            end
`endif
         end
         StRead: begin
            if (iss_q == lines_q) begin
               state_d = StDrain;
            end else begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + LW'(1);
               iss_d   = iss_q + cnt_t'(1);
            end
         end
         StDrain: begin
            // The final beat is on the outputs this cycle.
            if (bj_q == beats_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Request context, read pipeline and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_q     <= '0;
         nbytes_q  <= '0;
         lines_q   <= '0;
         beats_q   <= '0;
         iss_q     <= '0;
         rcv_q     <= '0;
         bj_q      <= '0;
         rd_pend_q <= 1'b0;
         line_q    <= '0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         vld_q     <= 1'b0;
`ifdef MEM_RD_RESP_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         off_q     <= off_d;
         nbytes_q  <= nbytes_d;
         lines_q   <= lines_d;
         beats_q   <= beats_d;
         iss_q     <= iss_d;
         rcv_q     <= rcv_d;
         bj_q      <= bj_d;
         rd_pend_q <= rd_pend_d;
         line_q    <= line_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
`ifdef MEM_RD_RESP_ERR_EN
         err_q     <= err_d;
`endif
      end
   end

   assign mem_data     = data_q;
   assign mem_data_vld = vld_q;
   assign mem_busy     = (state_q != StIdle);
   assign sram_rd_en   = rd_en_q;
   assign sram_addr    = addr_q;
`ifdef MEM_RD_RESP_ERR_EN
   assign mem_rd_err   = err_q;
`endif

endmodule

// File: tb/tb_mem_rd_responder.sv
// Directed bench for mem_rd_responder with a registered SRAM model whose byte values
// equal the low 8 bits of their byte address. Cycle numbers are counted at the falling
// edge; "acc" is the cycle that opens at the accept edge.
module tb_mem_rd_responder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [11:0]  mem_start_addr;
   logic [4:0]   mem_bytes;
   logic         mem_rd_req;
   logic [127:0] mem_data;
   logic         mem_data_vld;
   logic         mem_busy;
   logic         sram_rd_en;
   logic [7:0]   sram_addr;
   logic [127:0] sram_rdata;
`ifdef MEM_RD_RESP_ERR_EN
   logic         mem_rd_err;
`endif

   mem_rd_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_start_addr (mem_start_addr),
      .mem_bytes      (mem_bytes),
      .mem_rd_req     (mem_rd_req),
      .mem_data       (mem_data),
      .mem_data_vld   (mem_data_vld),
      .mem_busy       (mem_busy),
      .sram_rd_en     (sram_rd_en),
      .sram_addr      (sram_addr),
      .sram_rdata     (sram_rdata)
`ifdef MEM_RD_RESP_ERR_EN
      ,
      .mem_rd_err     (mem_rd_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM: line data one cycle after the strobe, garbage otherwise.
   logic [127:0] mem [256];
   always @(posedge clk) begin
      if (sram_rd_en) sram_rdata <= mem[sram_addr];
      else            sram_rdata <= {$urandom, $urandom, $urandom, $urandom};
   end

   // Falling-edge monitor.
   logic [127:0] bt_q[$];
   int           bt_cyc_q[$];
   int           rd_addr_q[$];
   int           rd_cyc_q[$];
   bit           busy_log [1024];
   int           zero_viol = 0;
   int           err_n = 0;
   int           err_cyc = -1;

   always @(negedge clk) begin
      if (rst_n) begin
         busy_log[cyc % 1024] = mem_busy;
         if (sram_rd_en) begin
            rd_addr_q.push_back(int'(sram_addr));
            rd_cyc_q.push_back(cyc);
         end
         if (mem_data_vld) begin
            bt_q.push_back(mem_data);
            bt_cyc_q.push_back(cyc);
         end else if (mem_data != '0) begin
            zero_viol++;
         end
`ifdef MEM_RD_RESP_ERR_EN
         if (mem_rd_err) begin
            err_n++;
            err_cyc = cyc;
         end
`endif
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] beat_at(input int i);
      if (i < bt_q.size()) return bt_q[i];
      return 'x;
   endfunction

   function automatic int bcyc_at(input int i);
      if (i < bt_cyc_q.size()) return bt_cyc_q[i];
      return -1;
   endfunction

   function automatic int raddr_at(input int i);
      if (i < rd_addr_q.size()) return rd_addr_q[i];
      return -1;
   endfunction

   function automatic int rcyc_at(input int i);
      if (i < rd_cyc_q.size()) return rd_cyc_q[i];
      return -1;
   endfunction

   function automatic bit busy_at(input int c);
      return busy_log[c % 1024];
   endfunction

   task automatic clear_logs();
      @(posedge clk);
      bt_q.delete();
      bt_cyc_q.delete();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      err_n   = 0;
      err_cyc = -1;
   endtask

   // One-cycle request; inputs are scrambled afterwards since they must no longer matter.
   task automatic send(input logic [11:0] addr, input logic [4:0] n, output int acc);
      @(negedge clk);
      mem_start_addr = addr;
      mem_bytes      = n;
      mem_rd_req     = 1'b1;
      @(negedge clk);
      acc            = cyc;
      mem_rd_req     = 1'b0;
      mem_start_addr = 12'hABC;
      mem_bytes      = 5'd7;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   int acc, acc2;

   initial begin
      mem_start_addr = '0;
      mem_bytes      = '0;
      mem_rd_req     = 1'b0;
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 16; k++) mem[i][8*k +: 8] = 8'(i * 16 + k);
      end

      // Reset state
      #3;
      check("rst_data", mem_data, '0);
      check("rst_vld", 128'(mem_data_vld), 128'd0);
      check("rst_busy", 128'(mem_busy), 128'd0);
      check("rst_rd_en", 128'(sram_rd_en), 128'd0);
      check("rst_addr", 128'(sram_addr), 128'd0);
`ifdef MEM_RD_RESP_ERR_EN
      check("rst_err", 128'(mem_rd_err), 128'd0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Aligned single line, line 4 holding 0x00..0x0F
      mem[4] = 128'h0F0E0D0C0B0A09080706050403020100;
      clear_logs();
      send(12'h040, 5'd16, acc);
      repeat (6) @(negedge clk);
      check("al_nreads", 128'(rd_addr_q.size()), 128'd1);
      check("al_raddr", 128'(raddr_at(0)), 128'd4);
      check("al_rcyc", 128'(rcyc_at(0)), 128'(acc));
      check("al_nbeats", 128'(bt_q.size()), 128'd1);
      check("al_beat", beat_at(0), 128'h0F0E0D0C0B0A09080706050403020100);
      check("al_bcyc", 128'(bcyc_at(0)), 128'(acc + 2));
      check("al_busy_in_beat", 128'(busy_at(acc + 2)), 128'd1);
      check("al_busy_after", 128'(busy_at(acc + 3)), 128'd0);
      mem[4] = 128'h4F4E4D4C4B4A49484746454443424140;

      // Unaligned three-line request
      clear_logs();
      send(12'h04F, 5'd20, acc);
      repeat (8) @(negedge clk);
      check("ua_nreads", 128'(rd_addr_q.size()), 128'd3);
      check("ua_raddr0", 128'(raddr_at(0)), 128'd4);
      check("ua_raddr1", 128'(raddr_at(1)), 128'd5);
      check("ua_raddr2", 128'(raddr_at(2)), 128'd6);
      check("ua_rcyc2", 128'(rcyc_at(2)), 128'(acc + 2));
      check("ua_nbeats", 128'(bt_q.size()), 128'd2);
      check("ua_beat0", beat_at(0), 128'h5E5D5C5B5A595857565554535251504F);
      check("ua_beat1", beat_at(1), 128'h0000000000000000000000006261605F);
      check("ua_bcyc0", 128'(bcyc_at(0)), 128'(acc + 3));
      check("ua_bcyc1", 128'(bcyc_at(1)), 128'(acc + 4));
      check("ua_busy_after", 128'(busy_at(acc + 5)), 128'd0);

      // Wrap past the top line
      clear_logs();
      send(12'hFF8, 5'd12, acc);
      repeat (7) @(negedge clk);
      check("wr_nreads", 128'(rd_addr_q.size()), 128'd2);
      check("wr_raddr0", 128'(raddr_at(0)), 128'd255);
      check("wr_raddr1", 128'(raddr_at(1)), 128'd0);
      check("wr_nbeats", 128'(bt_q.size()), 128'd1);
      check("wr_beat", beat_at(0), 128'h0000000003020100FFFEFDFCFBFAF9F8);

      // Request while busy is ignored; request right after the last beat is taken
      clear_logs();
      send(12'h020, 5'd16, acc);
      mem_start_addr = 12'h300;
      mem_bytes      = 5'd16;
      mem_rd_req     = 1'b1;
      @(negedge clk);
      mem_rd_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bz_idle_after_beat", 128'(mem_busy), 128'd0);
      mem_start_addr = 12'h030;
      mem_bytes      = 5'd16;
      mem_rd_req     = 1'b1;
      @(negedge clk);
      acc2       = cyc;
      mem_rd_req = 1'b0;
      repeat (6) @(negedge clk);
      check("bz_nreads", 128'(rd_addr_q.size()), 128'd2);
      check("bz_raddr0", 128'(raddr_at(0)), 128'd2);
      check("bz_raddr1", 128'(raddr_at(1)), 128'd3);
      check("bz_acc2_cyc", 128'(acc2), 128'(acc + 4));
      check("bz_rcyc1", 128'(rcyc_at(1)), 128'(acc2));
      check("bz_nbeats", 128'(bt_q.size()), 128'd2);
      check("bz_beat0", beat_at(0), 128'h2F2E2D2C2B2A29282726252423222120);
      check("bz_beat1", beat_at(1), 128'h3F3E3D3C3B3A39383736353433323130);
      check("bz_bcyc1", 128'(bcyc_at(1)), 128'(acc2 + 2));

      // Reset between the first and second line reads
      clear_logs();
      send(12'h04F, 5'd20, acc);
      #1;
      rst_n = 1'b0;
      #1;
      check("mr_data", mem_data, '0);
      check("mr_vld", 128'(mem_data_vld), 128'd0);
      check("mr_busy", 128'(mem_busy), 128'd0);
      check("mr_rd_en", 128'(sram_rd_en), 128'd0);
      check("mr_addr", 128'(sram_addr), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      repeat (10) @(negedge clk);
      check("mr_no_reads", 128'(rd_addr_q.size()), 128'd0);
      check("mr_no_beats", 128'(bt_q.size()), 128'd0);
      clear_logs();
      send(12'h0F0, 5'd16, acc);
      repeat (6) @(negedge clk);
      check("mr_next_raddr", 128'(raddr_at(0)), 128'd15);
      check("mr_next_nbeats", 128'(bt_q.size()), 128'd1);
      check("mr_next_beat", beat_at(0), 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

      // Zero-length and oversize requests
      clear_logs();
      send(12'h100, 5'd0, acc);
      repeat (6) @(negedge clk);
      check("n0_nreads", 128'(rd_addr_q.size()), 128'd0);
      check("n0_nbeats", 128'(bt_q.size()), 128'd0);
      check("n0_busy", 128'(busy_at(acc)), 128'd0);
`ifdef MEM_RD_RESP_ERR_EN
      check("n0_err_n", 128'(err_n), 128'd1);
      check("n0_err_cyc", 128'(err_cyc), 128'(acc));
`endif
      clear_logs();
      send(12'h100, 5'd25, acc);
      repeat (7) @(negedge clk);
`ifdef MEM_RD_RESP_ERR_EN
      check("n25_nreads", 128'(rd_addr_q.size()), 128'd0);
      check("n25_nbeats", 128'(bt_q.size()), 128'd0);
      check("n25_err_n", 128'(err_n), 128'd1);
      check("n25_err_cyc", 128'(err_cyc), 128'(acc));
`else
      check("n25_nreads", 128'(rd_addr_q.size()), 128'd2);
      check("n25_nbeats", 128'(bt_q.size()), 128'd2);
      check("n25_beat0", beat_at(0), 128'h0F0E0D0C0B0A09080706050403020100);
      check("n25_beat1", beat_at(1), 128'h00000000000000000000000013121110);
`endif

      check("data_zero_when_invalid", 128'(zero_viol), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
